// File: rtl/sprite_cmd_sequencer.sv
// Sprite command sequencer: buffers software command words and replays them onto the
// sprite command bus, holding ping/pong swap words until vertical blank.
module sprite_cmd_sequencer #(
    parameter int DEPTH       = 16,
    parameter int VBLANK_LINE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic        address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [31:0] cmd_out,
    output logic        swap_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
    localparam logic [9:0]    VBLANK_V    = 10'(VBLANK_LINE);

    typedef enum logic [1:0] {
        ST_DRAIN = 2'd0,
        ST_HOLD  = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    mem_q [DEPTH];
    logic [31:0]    mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    cmd_q, cmd_d;
    logic           swap_q, swap_d;
    logic [15:0]    frame_q, frame_d;
    logic [31:0]    readdata_q, readdata_d;

    logic           full_s;
    logic           empty_s;
    logic           fifo_wr_s;
    logic           push_s;
    logic           pop_s;
    logic           vblank_s;
    logic [31:0]    head_s;
    logic           head_swap_s;
    logic           unused_hcount_s;

    // A head word carrying info field 4'b1111 is a ping/pong buffer swap.
    function automatic logic is_swap_word(input logic [31:0] word);
        return (word[20:17] == 4'b1111);
    endfunction

    function automatic logic [31:0] status_word(
        input logic [CW-1:0] cnt,
        input logic          full,
        input logic          empty,
        input logic [1:0]    st,
        input logic [15:0]   frames
    );
        logic [31:0] w;
        w        = 32'h0000_0000;
        w[4:0]   = 5'(cnt);
        w[5]     = full;
        w[6]     = empty;
        w[8:7]   = st;
        w[31:16] = frames;
        return w;
    endfunction

    assign unused_hcount_s = ^hcount;

    assign full_s      = (count_q == FULL_COUNT);
    assign empty_s     = (count_q == {CW{1'b0}});
    assign fifo_wr_s   = chipselect & write & ~address;
    assign push_s      = fifo_wr_s & ~full_s;
    assign waitrequest = fifo_wr_s & full_s;
    assign vblank_s    = (vcount >= VBLANK_V);
    assign head_s      = mem_q[rd_ptr_q];
    assign head_swap_s = is_swap_word(head_s);

    assign cmd_out   = cmd_q;
    assign swap_done = swap_q;
    assign readdata  = readdata_q;

    // Sequencer FSM: decides pops and what goes onto the command bus next cycle.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        cmd_d   = 32'h0000_0000;
        swap_d  = 1'b0;
        frame_d = frame_q;
        case (state_q)
            ST_DRAIN: begin
                if (!empty_s) begin
                    if (head_swap_s) begin
                        state_d = ST_HOLD;
                    end else begin
                        pop_s = 1'b1;
                        cmd_d = head_s;
                    end
                end else begin
                    cmd_d = 32'h0000_0000;
                end
            end
            ST_HOLD: begin
                if (vblank_s) begin
                    pop_s   = 1'b1;
                    cmd_d   = head_s;
                    swap_d  = 1'b1;
                    frame_d = frame_q + 16'd1;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            // Only one swap per blanking interval: sit out the rest of vblank.
            ST_WAIT: begin
                if (vcount < VBLANK_V) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_DRAIN;
            end
        endcase
    end

    // FIFO storage, pointers and occupancy; full is judged before any same-cycle pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = writedata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Status read port: registered, address 0 reads back zero.
    always_comb begin
        readdata_d = readdata_q;
        if (chipselect && read) begin
            if (address) begin
                readdata_d = status_word(count_q, full_s, empty_s, state_q, frame_q);
            end else begin
                readdata_d = 32'h0000_0000;
            end
        end else begin
            readdata_d = readdata_q;
        end
    end

    // State register for all control, storage and output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_DRAIN;
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            cmd_q      <= 32'h0000_0000;
            swap_q     <= 1'b0;
            frame_q    <= 16'h0000;
            readdata_q <= 32'h0000_0000;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cmd_q      <= cmd_d;
            swap_q     <= swap_d;
            frame_q    <= frame_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sprite_cmd_sequencer.sv
// Directed self-checking bench for sprite_cmd_sequencer (DEPTH=16, VBLANK_LINE=480).
module tb_sprite_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic        address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [31:0] cmd_out;
    logic        swap_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int          cmd_cyc_q[$];
    logic [31:0] cmd_val_q[$];
    int          swp_cyc_q[$];
    int          exp_cyc_q[$];
    logic [31:0] exp_val_q[$];
    int          exp_swp_q[$];

    localparam logic [31:0] SWAP_W = 32'h001E_0000;

    sprite_cmd_sequencer #(.DEPTH(16), .VBLANK_LINE(480)) dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .hcount      (hcount),
        .vcount      (vcount),
        .cmd_out     (cmd_out),
        .swap_done   (swap_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every non-idle bus word and swap pulse with the cycle it was visible in.
    always @(negedge clk) begin
        if (cmd_out !== 32'h0) begin
            cmd_cyc_q.push_back(cyc);
            cmd_val_q.push_back(cmd_out);
        end
        if (swap_done === 1'b1) swp_cyc_q.push_back(cyc);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 1'b0;
    endtask

    task automatic avm_write(input logic [31:0] d, output int waits);
        chipselect = 1'b1;
        write      = 1'b1;
        read       = 1'b0;
        address    = 1'b0;
        writedata  = d;
        waits      = 0;
        #1;
        while (waitrequest === 1'b1 && waits < 100) begin
            tick();
            waits++;
        end
        if (waitrequest === 1'b1) check_eq("wr_bound", {31'h0, waitrequest}, 32'h0);
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic avm_read(input logic a, output logic [31:0] d);
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b0;
        address    = a;
        tick();
        d = readdata;
        bus_idle();
    endtask

    task automatic add_exp(input logic [31:0] v, input int c);
        exp_val_q.push_back(v);
        exp_cyc_q.push_back(c);
    endtask

    task automatic verify_log(input string tag);
        check_eq({tag, "_n"}, cmd_val_q.size(), exp_val_q.size());
        for (int i = 0; i < exp_val_q.size() && i < cmd_val_q.size(); i++) begin
            check_eq({tag, "_val"}, cmd_val_q[i], exp_val_q[i]);
            if (exp_cyc_q[i] >= 0) check_eq({tag, "_cyc"}, cmd_cyc_q[i], exp_cyc_q[i]);
        end
        check_eq({tag, "_swn"}, swp_cyc_q.size(), exp_swp_q.size());
        for (int i = 0; i < exp_swp_q.size() && i < swp_cyc_q.size(); i++) begin
            if (exp_swp_q[i] >= 0) check_eq({tag, "_swcyc"}, swp_cyc_q[i], exp_swp_q[i]);
        end
        cmd_cyc_q.delete();
        cmd_val_q.delete();
        swp_cyc_q.delete();
        exp_cyc_q.delete();
        exp_val_q.delete();
        exp_swp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] words[$];
        int          w;
        int          a;
        int          t;
        int          tot_waits;

        reset     = 1'b0;
        hcount    = 10'd0;
        vcount    = 10'd100;
        writedata = 32'h0;
        bus_idle();
        repeat (3) tick();
        check_eq("rst_cmd", cmd_out, 32'h0);
        check_eq("rst_readdata", readdata, 32'h0);
        check_eq("rst_swap", {31'h0, swap_done}, 32'h0);
        reset = 1'b1;
        tick();
        avm_read(1'b1, rd);
        check_eq("rst_status", rd, 32'h0000_0040);
        avm_read(1'b0, rd);
        check_eq("addr0_read", rd, 32'h0);

        // Three normal words back-to-back.
        avm_write(32'h0C02_4005, w);
        a = cyc;
        avm_write(32'h0C02_8064, w);
        avm_write(32'h0C02_C0C8, w);
        repeat (5) tick();
        add_exp(32'h0C02_4005, a + 1);
        add_exp(32'h0C02_8064, a + 2);
        add_exp(32'h0C02_C0C8, a + 3);
        verify_log("normal3");

        // Swap held outside vblank, issued at vcount=480.
        avm_write(SWAP_W, w);
        repeat (4) tick();
        avm_read(1'b1, rd);
        check_eq("hold_status", rd, 32'h0000_0081);
        verify_log("hold_idle");
        vcount = 10'd480;
        t = cyc;
        repeat (3) tick();
        add_exp(SWAP_W, t + 1);
        exp_swp_q.push_back(t + 1);
        verify_log("swap1");
        avm_read(1'b1, rd);
        check_eq("swap1_status", rd, 32'h0001_0140);

        // Swap + normal + swap during vblank.
        vcount = 10'd100;
        tick();
        vcount = 10'd480;
        avm_write(SWAP_W, w);
        a = cyc;
        avm_write(32'h0C02_4005, w);
        avm_write(SWAP_W, w);
        repeat (4) tick();
        add_exp(SWAP_W, a + 2);
        exp_swp_q.push_back(a + 2);
        verify_log("swap2");
        avm_read(1'b1, rd);
        check_eq("withheld_status", rd, 32'h0002_0102);
        vcount = 10'd0;
        t = cyc;
        repeat (4) tick();
        add_exp(32'h0C02_4005, t + 2);
        verify_log("after_vblank");
        avm_read(1'b1, rd);
        check_eq("second_hold_status", rd, 32'h0002_0081);
        vcount = 10'd480;
        t = cyc;
        repeat (3) tick();
        add_exp(SWAP_W, t + 1);
        exp_swp_q.push_back(t + 1);
        verify_log("swap3");
        avm_read(1'b1, rd);
        check_eq("swap3_status", rd, 32'h0003_0140);

        // Fill to full behind a held swap at line 479 (not yet blanking).
        vcount = 10'd479;
        tick();
        avm_write(SWAP_W, w);
        for (int i = 1; i <= 15; i++) begin
            words.push_back(32'h0A00_0100 + 32'(i));
            avm_write(32'h0A00_0100 + 32'(i), w);
        end
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 1'b1;
        writedata  = 32'hDEAD_BEEF;
        #1;
        check_eq("addr1_no_stall", {31'h0, waitrequest}, 32'h0);
        tick();
        bus_idle();
        avm_read(1'b1, rd);
        check_eq("full_status", rd, 32'h0003_00B0);
        verify_log("line479");
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 1'b0;
        writedata  = 32'h0A00_01FF;
        #1;
        check_eq("stall_full", {31'h0, waitrequest}, 32'h1);
        repeat (3) tick();
        check_eq("stall_held", {31'h0, waitrequest}, 32'h1);
        vcount = 10'd480;
        t = cyc;
        #1;
        check_eq("stall_pop_cycle", {31'h0, waitrequest}, 32'h1);
        tick();
        check_eq("stall_released", {31'h0, waitrequest}, 32'h0);
        tick();
        bus_idle();
        words.push_back(32'h0A00_01FF);
        add_exp(SWAP_W, t + 1);
        exp_swp_q.push_back(t + 1);
        repeat (2) tick();
        verify_log("swap4");
        avm_read(1'b1, rd);
        check_eq("refill_status", rd, 32'h0004_0130);

        // Drain the sixteen queued words in order.
        vcount = 10'd100;
        t = cyc;
        repeat (20) tick();
        for (int i = 0; i < 16; i++) add_exp(words[i], t + 2 + i);
        verify_log("drain16");

        // Fill 15 in WAIT_ACTIVE, then stream with simultaneous push/pop across the wrap.
        avm_write(SWAP_W, w);
        vcount = 10'd480;
        repeat (4) tick();
        add_exp(SWAP_W, -1);
        exp_swp_q.push_back(-1);
        verify_log("swap5");
        words.delete();
        for (int i = 0; i < 40; i++) words.push_back(32'h0B00_0000 + 32'(i + 1));
        for (int i = 0; i < 15; i++) avm_write(words[i], w);
        vcount = 10'd100;
        tick();
        t = cyc;
        tot_waits = 0;
        for (int i = 15; i < 40; i++) begin
            avm_write(words[i], w);
            tot_waits += w;
        end
        check_eq("stream_waits", tot_waits, 32'h0);
        avm_read(1'b1, rd);
        check_eq("stream_status", rd, 32'h0005_000F);
        repeat (20) tick();
        for (int i = 0; i < 40; i++) add_exp(words[i], t + 1 + i);
        verify_log("stream40");

        // Reset in HOLD with five words queued.
        avm_write(SWAP_W, w);
        for (int i = 0; i < 4; i++) avm_write(32'h0C02_4005, w);
        tick();
        avm_read(1'b1, rd);
        check_eq("prereset_status", rd, 32'h0005_0085);
        reset = 1'b0;
        #1;
        check_eq("reset_cmd", cmd_out, 32'h0);
        check_eq("reset_readdata", readdata, 32'h0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        avm_read(1'b1, rd);
        check_eq("postreset_status", rd, 32'h0000_0040);
        verify_log("reset_hold");

        // Reset clears a live bus word without waiting for a clock edge.
        avm_write(32'h0C02_8064, w);
        tick();
        check_eq("live_word", cmd_out, 32'h0C02_8064);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_cmd_clear", cmd_out, 32'h0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        cmd_cyc_q.delete();
        cmd_val_q.delete();
        swp_cyc_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
